i2c_write_engine: RTL and testbench
===================================

# i2c_write_engine

Bit-level I2C master that performs one 3-byte write transaction per request: START, slave-address byte, sub-address byte, data byte, STOP. It sits directly downstream of the AV configuration sequencer. It takes the sequencer's 24-bit `{SLAVE_ADDR, SUB_ADDR, DATA}` word and its GO level, and returns END/ACK status. It runs entirely on the system clock `iCLK` with an internal quarter-bit tick divider; no divided clock is exported.

## Interface
- `CLK_Freq`, default 25_000_000: `iCLK` frequency in Hz.
- `I2C_Freq`, default 100_000: SCL frequency in Hz.
- `TICK_DIV`, default `CLK_Freq/(4*I2C_Freq)` (= 62): `iCLK` cycles per quarter-bit phase. Must be ≥ 2.
- `iCLK`, in, 1: system clock.
- `iRST_N`, in, 1: reset, asynchronous, active-low.
- `iDATA`, in, 24: `[23:16]` slave address byte (R/W bit included), `[15:8]` sub-address, `[7:0]` data.
- `iGO`, in, 1: request level, asynchronous to `iCLK`. A 0→1 transition requests a transfer.
- `oEND`, out, 1: transfer-complete level.
- `oACK`, out, 1: 1 if any acknowledge slot sampled SDA high (NACK); 0 if all three bytes were ACKed. Valid while `oEND`=1.
- `I2C_SCLK`, out, 1: SCL, push-pull. Single master; no clock stretching.
- `I2C_SDAT`, inout, 1: SDA, open-drain. The block drives 0 or Z only.

## Operation
- `iGO` passes through a 2-flop synchronizer. A rising edge on the synchronized value is accepted only in IDLE or DONE. The acceptance cycle is the 3rd `iCLK` edge after `iGO` rises.
- On acceptance:
  - latch `iDATA` into a 24-bit shift register;
  - clear `oEND` and `oACK`;
  - reset the tick divider to 0;
  - enter START.
- Later changes on `iDATA` and `iGO` are ignored until DONE. Deasserting `iGO` mid-transfer does not abort.
- States: IDLE → START → BIT → STOP → DONE. DONE → START on the next accepted edge.
- Each state step is a "slot" of 4 phases (p0..p3), each phase `TICK_DIV` cycles long.
- START slot:
  - p0–p1: SCL=1, SDA=Z;
  - p2: SDA=0;
  - p3: SCL=0.
- BIT state, 27 slots, counter 0..26. Slot n carries byte n/9 and bit n%9:
  - For n%9 < 8: p0 drives SDA from shift-register MSB (0 → drive 0, 1 → Z), SCL=0. p1–p2 SCL=1. p3 SCL=0, shift left by 1.
  - For n%9 = 8 (ACK slot): SDA=Z for the whole slot. `I2C_SDAT` is sampled at the last cycle of p2, and `oACK` becomes `oACK | sample`.
- STOP slot:
  - p0: SCL=0, SDA=0;
  - p1: SCL=1;
  - p2–p3: SDA=Z.
- DONE: `oEND`=1 and `oACK` holds. SCL=1, SDA=Z. Stays here until the next accepted `iGO` edge.
- A NACK never shortens the transfer. All 27 bit slots and STOP always execute; the sequencer decides on retry.
- Reset values, async and immediate in any state: state IDLE, `oEND`=0, `oACK`=0, `I2C_SCLK`=1, `I2C_SDAT`=Z, divider 0, bit counter 0.
- IDLE outputs are the same as the reset values.

## Timing
- Transfer length: 29 slots × 4 phases × `TICK_DIV` cycles. With defaults this is 116 × 62 = 7192 `iCLK` cycles from the acceptance cycle to the cycle `oEND` rises.
- `oEND` falls on the acceptance cycle, so within 3 `iCLK` cycles of `iGO` rising. This guarantees the slow-clocked sequencer never sees a stale `oEND`=1 after raising GO.
- `oACK` is final before `oEND` rises. It is updated only at the three ACK sample points.
- SDA changes only while SCL=0, except the START p2 and STOP p2 edges.
- SDA samples use the raw pad value registered once. The sample point is mid-SCL-high.
- `iGO` held high through DONE starts nothing. A new transfer requires `iGO` to go low and then high, with each level lasting at least 2 `iCLK` cycles.
- `iGO` rising on the same cycle `oEND` rises is not a valid request. The edge is accepted only if it is still present once the block is in DONE.

## Test plan
- Full ACK transfer: `iDATA`=24'hBA0A80, slave model ACKs all bytes, pulse `iGO`.
  - SDA bits at SCL rising edges: 10111010 A 00001010 A 10000000 A, framed by START/STOP.
  - `oACK`=0; `oEND` rises exactly 7192 cycles after acceptance.
- Address NACK: `iDATA`=24'hB90F02, slave leaves SDA high on the first ACK slot only.
  - `oACK`=1; all 27 bit slots and STOP still occur; `oEND`=1.
- Back-to-back handshake: after DONE, drop `iGO` for 5 cycles, then raise it.
  - `oEND` falls within 3 cycles; `oACK` clears to 0; a second transfer with the new `iDATA` completes.
- Reset mid-transfer: assert `iRST_N`=0 at BIT slot 12 p1.
  - Same cycle: SCL=1, SDA=Z, `oEND`=0, `oACK`=0.
  - After release, no bus activity until a fresh `iGO` edge.
- Input stability: change `iDATA` to 24'h000000 and drop `iGO` during BIT slot 3.
  - Bus bits still match the originally latched word.
  - Holding `iGO` high after `oEND` triggers no second transfer.

Source files
------------

// File: rtl/i2c_write_engine_if.sv
// rtl/i2c_write_engine_if.sv - sequencer handshake bundle for the I2C write engine
interface i2c_write_engine_if;
   logic [23:0] iDATA;
   logic        iGO;
   logic        oEND;
   logic        oACK;

   modport master (output iDATA, output iGO, input oEND, input oACK);
   modport slave  (input iDATA, input iGO, output oEND, output oACK);
endinterface

// File: rtl/i2c_write_engine.sv
// rtl/i2c_write_engine.sv - bit-level I2C master for one 3-byte write per request
module i2c_write_engine #(
   parameter int CLK_Freq = 25_000_000,
   parameter int I2C_Freq = 100_000,
   parameter int TICK_DIV = CLK_Freq / (4 * I2C_Freq)
) (
   input  logic                iCLK,
   input  logic                iRST_N,
   i2c_write_engine_if.slave   bus,
   output logic                I2C_SCLK,
   inout  wire                 I2C_SDAT
);

   localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BIT,
      S_STOP,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [1:0]         phase_q, phase_d;
   logic [4:0]         bit_cnt_q, bit_cnt_d;
   logic [23:0]        shift_q, shift_d;
   logic               end_q, end_d;
   logic               ack_q, ack_d;
   logic [2:0]         go_sync_q, go_sync_d;
   logic               sda_in_q, sda_in_d;

   logic               go_rise;
   logic               last_tick;
   logic               slot_end;
   logic               ack_slot;
   logic               scl_c;
   logic               sda_low_c;

   // Stage 3 of the GO pipeline only remembers the previous synchronized level.
   assign go_rise   = go_sync_q[1] & ~go_sync_q[2];
   assign last_tick = (div_q == DIV_W'(TICK_DIV - 1));
   assign slot_end  = last_tick && (phase_q == 2'd3);
   assign ack_slot  = (bit_cnt_q == 5'd8) || (bit_cnt_q == 5'd17) || (bit_cnt_q == 5'd26);

   // State, divider, shift register, status and input-capture flops.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         phase_q   <= 2'd0;
         bit_cnt_q <= 5'd0;
         shift_q   <= 24'd0;
         end_q     <= 1'b0;
         ack_q     <= 1'b0;
         go_sync_q <= 3'b000;
         sda_in_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         phase_q   <= phase_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         end_q     <= end_d;
         ack_q     <= ack_d;
         go_sync_q <= go_sync_d;
         sda_in_q  <= sda_in_d;
      end
   end

   // Next-state and bus-pin decode; SCL/SDA are a pure function of the registered slot position.
   always_comb begin
      state_d   = state_q;
      div_d     = last_tick ? '0 : div_q + DIV_W'(1);
      phase_d   = last_tick ? phase_q + 2'd1 : phase_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      end_d     = end_q;
      ack_d     = ack_q;
      go_sync_d = {go_sync_q[1:0], bus.iGO};
      sda_in_d  = I2C_SDAT;
      scl_c     = 1'b1;
      sda_low_c = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            div_d   = '0;
            phase_d = 2'd0;
            if (go_rise) begin
               state_d   = S_START;
               shift_d   = bus.iDATA;
               end_d     = 1'b0;
               ack_d     = 1'b0;
               bit_cnt_d = 5'd0;
            end
         end
         S_START: begin
            scl_c     = (phase_q != 2'd3);
            sda_low_c = phase_q[1];
            if (slot_end) begin
               state_d   = S_BIT;
               bit_cnt_d = 5'd0;
            end
         end
         S_BIT: begin
            scl_c     = (phase_q == 2'd1) || (phase_q == 2'd2);
            sda_low_c = !ack_slot && !shift_q[23];
            if (ack_slot && (phase_q == 2'd2) && last_tick) begin
               ack_d = ack_q | sda_in_q;
            end
            if (slot_end) begin
               // Data holds across the whole slot and moves on at the SCL-low boundary.
               if (!ack_slot) begin
                  shift_d = {shift_q[22:0], 1'b0};
               end
               if (bit_cnt_q == 5'd26) begin
                  state_d = S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end
         S_STOP: begin
            scl_c     = (phase_q != 2'd0);
            sda_low_c = !phase_q[1];
            if (slot_end) begin
               state_d = S_DONE;
               end_d   = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign I2C_SCLK = scl_c;
   assign I2C_SDAT = sda_low_c ? 1'b0 : 1'bz;
   assign bus.oEND = end_q;
   assign bus.oACK = ack_q;

endmodule

// File: tb/tb_i2c_write_engine.sv
// tb/tb_i2c_write_engine.sv - self-checking bench for i2c_write_engine
module tb_i2c_write_engine;

   localparam int T    = 62;
   localparam int SLOT = 4 * T;
   localparam int XFER = 29 * SLOT;

   logic iCLK   = 1'b0;
   logic iRST_N = 1'b0;
   always #5 iCLK = ~iCLK;

   i2c_write_engine_if bus ();
   wire  scl_w;
   wire  sda_w;
   logic slave_low = 1'b0;

   pullup (sda_w);
   assign sda_w = slave_low ? 1'b0 : 1'bz;

   i2c_write_engine dut (
      .iCLK     (iCLK),
      .iRST_N   (iRST_N),
      .bus      (bus),
      .I2C_SCLK (scl_w),
      .I2C_SDAT (sda_w)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bus monitor and slave: START/STOP detection, bit capture at SCL rise, ACK drive.
   logic [2:0]  nack_mask = 3'b000;
   logic [26:0] bits_got  = '0;
   int nbits  = 0;
   int starts = 0;
   int stops  = 0;
   int fc     = 100;

   always @(negedge sda_w) if (iRST_N && scl_w === 1'b1) begin starts++; fc = -1; end
   always @(posedge sda_w) if (iRST_N && scl_w === 1'b1) stops++;
   always @(posedge scl_w) if (iRST_N) begin
      if (nbits < 27) bits_got[26 - nbits] = sda_w;
      nbits++;
   end
   always @(negedge scl_w or negedge iRST_N) begin
      if (!iRST_N) begin
         slave_low = 1'b0;
         fc = 100;
      end else begin
         fc++;
         if (fc >= 8 && fc <= 26 && (fc % 9) == 8) slave_low = !nack_mask[fc / 9];
         else slave_low = 1'b0;
      end
   end

   // Reference model: acceptance 3 edges after GO rises, then outputs are a function of elapsed cycles.
   int          cyc = 0;
   int          t0 = 0;
   int          rise_cyc = -100;
   bit          started = 1'b0;
   logic        go_seen = 1'b0;
   logic [23:0] m_word = '0;
   logic [2:0]  m_nack = '0;

   always @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         cyc = 0; started = 1'b0; go_seen = 1'b0; rise_cyc = -100;
      end else begin
         cyc++;
         if (bus.iGO && !go_seen) rise_cyc = cyc;
         go_seen = bus.iGO;
         if (cyc == rise_cyc + 2 && !(started && (cyc - t0) <= XFER)) begin
            started = 1'b1;
            t0      = cyc;
            m_word  = bus.iDATA;
            m_nack  = nack_mask;
         end
      end
   end

   function automatic logic [3:0] model_out(input int k, input logic [23:0] w,
                                             input logic [2:0] nm, input bit st);
      logic scl, sda, en, ak;
      int   s, p, n, b;
      scl = 1'b1; sda = 1'b1; en = 1'b0; ak = 1'b0;
      if (st) begin
         for (int j = 0; j < 3; j++)
            if (k >= (4 * (9 + 9 * j) + 3) * T) ak = ak | nm[j];
         if (k >= XFER) en = 1'b1;
         else begin
            s = k / SLOT;
            p = (k / T) % 4;
            if (s == 0) begin
               scl = (p < 3); sda = (p < 2);
            end else if (s <= 27) begin
               n = s - 1; b = n % 9;
               scl = (p == 1 || p == 2);
               sda = (b == 8) ? 1'b1 : w[23 - 8 * (n / 9) - b];
            end else begin
               scl = (p >= 1); sda = (p >= 2);
            end
         end
      end
      return {scl, sda, en, ak};
   endfunction

   // Cycle-by-cycle comparison of pins and status against the model.
   always @(negedge iCLK) begin
      logic [3:0] e;
      if (iRST_N) begin
         e = model_out(cyc - t0, m_word, m_nack, started);
         e[2] = e[2] & ~slave_low;
         check("bus_cycle scl/sda/end/ack", {60'd0, scl_w, sda_w, bus.oEND, bus.oACK}, {60'd0, e});
      end
   end

   task automatic run_xfer(input logic [23:0] w, input logic [2:0] nm, input int disturb_at,
                           input int reset_at, output int lat, output int fall_lat,
                           output logic ack_at_fall);
      bit seen_low = 1'b0;
      bus.iDATA = w; nack_mask = nm;
      nbits = 0; bits_got = '0; starts = 0; stops = 0;
      fall_lat = -1; ack_at_fall = 1'bx; lat = 0;
      @(negedge iCLK);
      bus.iGO = 1'b1;
      for (int i = 1; i <= XFER + 100; i++) begin
         @(posedge iCLK); #1;
         lat = i;
         if (i == disturb_at) begin bus.iDATA = 24'h000000; bus.iGO = 1'b0; end
         if (i == reset_at) begin
            bus.iGO = 1'b0;
            iRST_N  = 1'b0;
            #1;
            check("reset_scl",  {63'd0, scl_w},    64'd1);
            check("reset_sda",  {63'd0, sda_w},    64'd1);
            check("reset_oEND", {63'd0, bus.oEND}, 64'd0);
            check("reset_oACK", {63'd0, bus.oACK}, 64'd0);
            return;
         end
         if (!seen_low && bus.oEND === 1'b0) begin
            seen_low = 1'b1; fall_lat = i; ack_at_fall = bus.oACK;
         end
         if (seen_low && bus.oEND === 1'b1) return;
      end
      check("end_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int lat, fl;
      logic af;
      bus.iGO = 1'b0; bus.iDATA = 24'd0;
      repeat (3) @(negedge iCLK);
      check("rst_scl",  {63'd0, scl_w},    64'd1);
      check("rst_sda",  {63'd0, sda_w},    64'd1);
      check("rst_oEND", {63'd0, bus.oEND}, 64'd0);
      check("rst_oACK", {63'd0, bus.oACK}, 64'd0);
      iRST_N = 1'b1;
      repeat (5) @(negedge iCLK);

      // Full ACK transfer; GO stays high afterwards.
      run_xfer(24'hBA0A80, 3'b000, -1, -1, lat, fl, af);
      check("t1_latency", lat, 64'd7195);
      check("t1_bits",    {37'd0, bits_got}, {37'd0, 27'b101110100_000010100_100000000});
      check("t1_scl_rises", nbits, 64'd28);
      check("t1_starts",  starts, 64'd1);
      check("t1_stops",   stops,  64'd1);
      check("t1_oACK",    {63'd0, bus.oACK}, 64'd0);
      repeat (300) @(negedge iCLK);
      check("t1_go_held_starts", starts, 64'd1);
      check("t1_go_held_oEND", {63'd0, bus.oEND}, 64'd1);
      bus.iGO = 1'b0;
      repeat (5) @(negedge iCLK);

      // Address NACK.
      run_xfer(24'hB90F02, 3'b001, -1, -1, lat, fl, af);
      check("t2_bits",  {37'd0, bits_got}, {37'd0, 27'b101110011_000011110_000000100});
      check("t2_oACK",  {63'd0, bus.oACK}, 64'd1);
      check("t2_oEND",  {63'd0, bus.oEND}, 64'd1);
      check("t2_scl_rises", nbits, 64'd28);
      check("t2_stops", stops, 64'd1);
      check("t2_latency", lat, 64'd7195);

      // Back-to-back handshake.
      bus.iGO = 1'b0;
      repeat (5) @(negedge iCLK);
      run_xfer(24'h3C55AA, 3'b000, -1, -1, lat, fl, af);
      check("t3_fall_latency", fl, 64'd3);
      check("t3_ack_cleared", {63'd0, af}, 64'd0);
      check("t3_bits", {37'd0, bits_got}, {37'd0, 27'b001111000_010101010_101010100});
      check("t3_oACK", {63'd0, bus.oACK}, 64'd0);

      // Input stability: iDATA and GO disturbed during BIT slot 3.
      bus.iGO = 1'b0;
      repeat (5) @(negedge iCLK);
      run_xfer(24'h5A3CC3, 3'b000, 3 + 4 * SLOT + T, -1, lat, fl, af);
      check("t4_bits", {37'd0, bits_got}, {37'd0, 27'b010110100_001111000_110000110});
      check("t4_oEND", {63'd0, bus.oEND}, 64'd1);
      check("t4_latency", lat, 64'd7195);

      // Reset at BIT slot 12 p1.
      bus.iGO = 1'b0;
      repeat (5) @(negedge iCLK);
      run_xfer(24'hA5F00F, 3'b000, -1, 3 + 13 * SLOT + T, lat, fl, af);
      repeat (3) @(negedge iCLK);
      starts = 0; stops = 0; nbits = 0;
      iRST_N = 1'b1;
      repeat (500) @(negedge iCLK);
      check("t5_no_start", starts, 64'd0);
      check("t5_no_scl",   nbits,  64'd0);
      check("t5_idle_pins", {62'd0, scl_w, sda_w}, 64'd3);
      check("t5_oEND", {63'd0, bus.oEND}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL global_timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

endmodule
